lnrv_icb2apb: RTL and testbench
===============================

LNRV_ICB2APB -- requirements
Module: lnrv_icb2apb

Interface
REQ-001 Parameter P_ADDR_WIDTH, default 32, SHALL set the address width of the ICB and APB sides.
REQ-002 Parameter P_DATA_WIDTH, default 32, SHALL set the data width of both sides; strobe width is P_DATA_WIDTH/8.
REQ-003 Parameter P_TIMEOUT, default 255, SHALL set the maximum number of ACCESS cycles before abort; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 icb_cmd_vld  input  1  ICB command valid.
REQ-007 icb_cmd_rdy  output  1  ICB command ready.
REQ-008 icb_cmd_write  input  1  1 = write, 0 = read.
REQ-009 icb_cmd_addr  input  P_ADDR_WIDTH  byte address.
REQ-010 icb_cmd_wdata  input  P_DATA_WIDTH  write data.
REQ-011 icb_cmd_wstrb  input  P_DATA_WIDTH/8  write byte strobes.
REQ-012 icb_cmd_size  input  3  access size; not used by this block.
REQ-013 icb_rsp_vld  output  1  response valid.
REQ-014 icb_rsp_rdy  input  1  response ready.
REQ-015 icb_rsp_err  output  1  response error.
REQ-016 icb_rsp_rdata  output  P_DATA_WIDTH  read data.
REQ-017 apb_psel, apb_penable, apb_pwrite  output  1 each  APB control.
REQ-018 apb_paddr  output  P_ADDR_WIDTH; apb_pwdata  output  P_DATA_WIDTH; apb_pstrb  output  P_DATA_WIDTH/8; apb_pprot  output  3.
REQ-019 apb_pready, apb_pslverr  input  1 each; apb_prdata  input  P_DATA_WIDTH.

Function
REQ-020 The block SHALL implement a four-state FSM: IDLE, SETUP, ACCESS, RSP; at most one transfer in flight.
REQ-021 icb_cmd_rdy SHALL be 1 only in IDLE; a command handshake (vld & rdy) SHALL register write, addr, wdata, wstrb and move to SETUP.
REQ-022 In SETUP the block SHALL drive psel=1, penable=0 for exactly one cycle, then move to ACCESS.
REQ-023 In ACCESS the block SHALL drive psel=1, penable=1; apb_paddr/pwrite/pwdata/pstrb SHALL stay constant across SETUP and ACCESS.
REQ-024 apb_pstrb SHALL equal the registered wstrb for writes and all-zero for reads; apb_pprot SHALL be 3'b000.
REQ-025 On pready=1 in ACCESS the block SHALL capture prdata (reads; zero for writes) and pslverr into response registers and move to RSP.
REQ-026 An 8-bit-or-wider wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; on reaching P_TIMEOUT (P_TIMEOUT != 0) the block SHALL deassert psel/penable, set err=1, rdata=0, and move to RSP.
REQ-027 If pready=1 in the same cycle the counter reaches P_TIMEOUT, pready SHALL win (normal completion).
REQ-028 In RSP icb_rsp_vld SHALL be 1 with rsp_err/rsp_rdata stable until icb_rsp_rdy=1, then move to IDLE; no new command accepted in that cycle.
REQ-029 Minimum latency: command handshake at cycle N, psel at N+1, penable at N+2, icb_rsp_vld at N+3 if pready=1 at N+2.
REQ-030 Outside SETUP/ACCESS psel and penable SHALL be 0; icb_rsp_vld SHALL be 0 outside RSP.

Reset
REQ-031 On reset_n=0, asynchronously: FSM=IDLE, counter=0, psel=penable=0, icb_rsp_vld=0, icb_rsp_err=0, icb_rsp_rdata=0, all registered address/data/strobe=0; icb_cmd_rdy=1 after reset.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no response issued after reset release.

Verification
REQ-033 Write addr 0x1000, wdata 0xA5A5_5A5A, wstrb 4'hF, pready=1 immediately -> psel at N+1, penable at N+2, pwrite=1, pstrb=4'hF, rsp_vld at N+3, err=0.
REQ-034 Read addr 0x2004, pready low 3 ACCESS cycles, prdata 0x1234_5678 -> ACCESS lasts 4 cycles, rsp_rdata=0x1234_5678, pstrb=0.
REQ-035 Read with pslverr=1 at pready -> rsp_err=1; rsp held 5 cycles with rsp_rdy=0, values stable; cmd_rdy=0 throughout.
REQ-036 P_TIMEOUT=4, pready stuck 0 -> psel drops after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-037 Back-to-back commands with cmd_vld held 1 -> second handshake only the cycle after rsp handshake; reset mid-ACCESS -> psel=0 immediately, no rsp_vld afterwards.

Source files
------------

// File: rtl/lnrv_icb2apb.sv
`default_nettype none
// ==========================================================================
// lnrv_icb2apb : ICB-to-APB bridge, one transfer in flight, ACCESS timeout
// Revision: 1.0
// ==========================================================================
module lnrv_icb2apb #(
  parameter int P_ADDR_WIDTH = 32,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      icb_cmd_vld,
  output logic                      icb_cmd_rdy,
  input  logic                      icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]   icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]   icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0] icb_cmd_wstrb,
  input  logic [2:0]                icb_cmd_size,
  output logic                      icb_rsp_vld,
  input  logic                      icb_rsp_rdy,
  output logic                      icb_rsp_err,
  output logic [P_DATA_WIDTH-1:0]   icb_rsp_rdata,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [P_ADDR_WIDTH-1:0]   apb_paddr,
  output logic [P_DATA_WIDTH-1:0]   apb_pwdata,
  output logic [P_DATA_WIDTH/8-1:0] apb_pstrb,
  output logic [2:0]                apb_pprot,
  input  logic                      apb_pready,
  input  logic                      apb_pslverr,
  input  logic [P_DATA_WIDTH-1:0]   apb_prdata
);

  localparam int C_STRB_WIDTH = P_DATA_WIDTH / 8;
  localparam int C_CNT_WIDTH  = (P_TIMEOUT > 255) ? $clog2(P_TIMEOUT + 1) : 8;
  localparam logic [C_CNT_WIDTH-1:0] C_CNT_LAST =
    (P_TIMEOUT > 0) ? C_CNT_WIDTH'(P_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RSP    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_write;
  logic [P_ADDR_WIDTH-1:0]   r_addr;
  logic [P_DATA_WIDTH-1:0]   r_wdata;
  logic [C_STRB_WIDTH-1:0]   r_wstrb;
  logic [C_CNT_WIDTH-1:0]    r_cnt;
  logic                      r_rsp_err;
  logic [P_DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                      w_cmd_hsk;
  logic                      w_timeout;
  logic                      w_unused_size;

  assign w_unused_size = ^icb_cmd_size;

  assign w_cmd_hsk = icb_cmd_vld && (r_state == ST_IDLE);
  // The counter would reach P_TIMEOUT on this edge; a simultaneous pready wins.
  assign w_timeout = (P_TIMEOUT != 0) && (r_state == ST_ACCESS) &&
                     !apb_pready && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (icb_cmd_vld) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (apb_pready || w_timeout) w_state_nxt = ST_RSP;
      ST_RSP:    if (icb_rsp_rdy) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_cmd_hsk) begin
        r_write <= icb_cmd_write;
        r_addr  <= icb_cmd_addr;
        r_wdata <= icb_cmd_wdata;
        r_wstrb <= icb_cmd_write ? icb_cmd_wstrb : '0;
      end

      if (r_state == ST_SETUP) begin
        r_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !apb_pready) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_ACCESS) begin
        if (apb_pready) begin
          r_rsp_err   <= apb_pslverr;
          r_rsp_rdata <= r_write ? '0 : apb_prdata;
        end else if (w_timeout) begin
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= '0;
        end
      end
    end
  end

  assign icb_cmd_rdy   = (r_state == ST_IDLE);
  assign icb_rsp_vld   = (r_state == ST_RSP);
  assign icb_rsp_err   = r_rsp_err;
  assign icb_rsp_rdata = r_rsp_rdata;

  assign apb_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign apb_penable = (r_state == ST_ACCESS);
  assign apb_pwrite  = r_write;
  assign apb_paddr   = r_addr;
  assign apb_pwdata  = r_wdata;
  assign apb_pstrb   = r_wstrb;
  assign apb_pprot   = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_lnrv_icb2apb.sv
`default_nettype none
// ==========================================================================
// tb_lnrv_icb2apb : directed scoreboard bench for the ICB-to-APB bridge
// Revision: 1.0
// ==========================================================================
module tb_lnrv_icb2apb;

  localparam int TO = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        icb_cmd_vld, icb_cmd_rdy, icb_cmd_write;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wstrb;
  logic [2:0]  icb_cmd_size;
  logic        icb_rsp_vld, icb_rsp_rdy, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_paddr, apb_pwdata;
  logic [3:0]  apb_pstrb;
  logic [2:0]  apb_pprot;
  logic        apb_pready, apb_pslverr;
  logic [31:0] apb_prdata;

  rsp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  lnrv_icb2apb #(
    .P_ADDR_WIDTH(32),
    .P_DATA_WIDTH(32),
    .P_TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .icb_cmd_vld  (icb_cmd_vld),
    .icb_cmd_rdy  (icb_cmd_rdy),
    .icb_cmd_write(icb_cmd_write),
    .icb_cmd_addr (icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wstrb(icb_cmd_wstrb),
    .icb_cmd_size (icb_cmd_size),
    .icb_rsp_vld  (icb_rsp_vld),
    .icb_rsp_rdy  (icb_rsp_rdy),
    .icb_rsp_err  (icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata),
    .apb_psel     (apb_psel),
    .apb_penable  (apb_penable),
    .apb_pwrite   (apb_pwrite),
    .apb_paddr    (apb_paddr),
    .apb_pwdata   (apb_pwdata),
    .apb_pstrb    (apb_pstrb),
    .apb_pprot    (apb_pprot),
    .apb_pready   (apb_pready),
    .apb_pslverr  (apb_pslverr),
    .apb_prdata   (apb_prdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rsp(input string nm);
    rsp_t e;
    chk({nm, ":rsp_vld"}, {31'd0, icb_rsp_vld}, 32'd1);
    chk({nm, ":sb_nonempty"}, {31'd0, exp_q.size() > 0}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, ":rsp_err"}, {31'd0, icb_rsp_err}, {31'd0, e.err});
      chk({nm, ":rsp_rdata"}, icb_rsp_rdata, e.rdata);
    end
  endtask

  // One complete transfer; waits >= TO means the slave never answers.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int waits, input logic serr,
                      input logic [31:0] rd, input int hold, input string nm);
    logic to;
    int   acc;
    rsp_t e;
    logic err_hold;
    logic [31:0] rdata_hold;
    to      = (waits >= TO);
    acc     = to ? TO : waits + 1;
    e.err   = to | serr;
    e.rdata = (wr | to) ? 32'h0 : rd;

    icb_cmd_vld = 1'b1; icb_cmd_write = wr; icb_cmd_addr = a;
    icb_cmd_wdata = d; icb_cmd_wstrb = s; icb_cmd_size = 3'd2;
    apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = 32'h0;
    chk({nm, ":cmd_rdy"}, {31'd0, icb_cmd_rdy}, 32'd1);
    exp_q.push_back(e);
    cyc();
    icb_cmd_vld = 1'b0; icb_cmd_addr = '1; icb_cmd_wdata = '1; icb_cmd_wstrb = '1;
    chk({nm, ":setup_psel"}, {31'd0, apb_psel}, 32'd1);
    chk({nm, ":setup_penable"}, {31'd0, apb_penable}, 32'd0);
    chk({nm, ":setup_paddr"}, apb_paddr, a);
    chk({nm, ":setup_pwrite"}, {31'd0, apb_pwrite}, {31'd0, wr});
    chk({nm, ":setup_pstrb"}, {28'd0, apb_pstrb}, wr ? {28'd0, s} : 32'd0);
    chk({nm, ":pprot"}, {29'd0, apb_pprot}, 32'd0);
    chk({nm, ":setup_cmd_rdy"}, {31'd0, icb_cmd_rdy}, 32'd0);
    if (wr) chk({nm, ":setup_pwdata"}, apb_pwdata, d);
    for (int i = 0; i < acc; i++) begin
      cyc();
      apb_pready  = (!to && i == waits);
      apb_pslverr = serr;
      apb_prdata  = rd;
      chk({nm, ":acc_psel"}, {31'd0, apb_psel}, 32'd1);
      chk({nm, ":acc_penable"}, {31'd0, apb_penable}, 32'd1);
      chk({nm, ":acc_paddr"}, apb_paddr, a);
      chk({nm, ":acc_pstrb"}, {28'd0, apb_pstrb}, wr ? {28'd0, s} : 32'd0);
      chk({nm, ":acc_rsp_vld"}, {31'd0, icb_rsp_vld}, 32'd0);
      if (wr) chk({nm, ":acc_pwdata"}, apb_pwdata, d);
    end
    cyc();
    apb_pready = 1'b0; apb_pslverr = 1'b1; apb_prdata = 32'hFFFF_FFFF;
    chk({nm, ":rsp_psel"}, {31'd0, apb_psel}, 32'd0);
    chk({nm, ":rsp_penable"}, {31'd0, apb_penable}, 32'd0);
    check_rsp(nm);
    err_hold   = e.err;
    rdata_hold = e.rdata;
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk({nm, ":hold_vld"}, {31'd0, icb_rsp_vld}, 32'd1);
      chk({nm, ":hold_err"}, {31'd0, icb_rsp_err}, {31'd0, err_hold});
      chk({nm, ":hold_rdata"}, icb_rsp_rdata, rdata_hold);
      chk({nm, ":hold_cmd_rdy"}, {31'd0, icb_cmd_rdy}, 32'd0);
    end
    icb_rsp_rdy = 1'b1;
    cyc();
    icb_rsp_rdy = 1'b0;
    apb_pslverr = 1'b0;
    chk({nm, ":done_vld"}, {31'd0, icb_rsp_vld}, 32'd0);
    chk({nm, ":done_cmd_rdy"}, {31'd0, icb_cmd_rdy}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    icb_cmd_vld = 1'b0; icb_cmd_write = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wstrb = '0; icb_cmd_size = 3'd0;
    icb_rsp_rdy = 1'b0; apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = '0;
    repeat (3) @(negedge clk);
    chk("rst:psel", {31'd0, apb_psel}, 32'd0);
    chk("rst:penable", {31'd0, apb_penable}, 32'd0);
    chk("rst:rsp_vld", {31'd0, icb_rsp_vld}, 32'd0);
    chk("rst:rsp_err", {31'd0, icb_rsp_err}, 32'd0);
    chk("rst:rsp_rdata", icb_rsp_rdata, 32'd0);
    chk("rst:cmd_rdy", {31'd0, icb_cmd_rdy}, 32'd1);
    chk("rst:paddr", apb_paddr, 32'd0);
    chk("rst:pstrb", {28'd0, apb_pstrb}, 32'd0);
    reset_n = 1'b1;
    cyc();

    xfer(1'b1, 32'h1000, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0, "wr_fast");
    xfer(1'b0, 32'h2004, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 0, "rd_wait3");
    xfer(1'b0, 32'h2008, 32'h0, 4'hF, 0, 1'b1, 32'hCAFE_F00D, 5, "rd_slverr");
    xfer(1'b1, 32'h200C, 32'h0BAD_F00D, 4'h3, 1, 1'b0, 32'h7777_7777, 1, "wr_strb3");
    xfer(1'b0, 32'h2010, 32'h0, 4'hF, 10, 1'b0, 32'h5555_AAAA, 0, "rd_timeout");
    xfer(1'b1, 32'h2014, 32'h1357_9BDF, 4'hC, 10, 1'b0, 32'h0, 2, "wr_timeout");

    // Back-to-back with command valid held high.
    icb_cmd_vld = 1'b1; icb_cmd_write = 1'b1; icb_cmd_addr = 32'h3000;
    icb_cmd_wdata = 32'h1122_3344; icb_cmd_wstrb = 4'hF;
    apb_pready = 1'b1; apb_pslverr = 1'b0; apb_prdata = 32'h5566_7788; icb_rsp_rdy = 1'b1;
    chk("b2b:cmd_rdy0", {31'd0, icb_cmd_rdy}, 32'd1);
    exp_q.push_back('{err: 1'b0, rdata: 32'h0});
    cyc();
    chk("b2b:setup_psel", {31'd0, apb_psel}, 32'd1);
    chk("b2b:setup_penable", {31'd0, apb_penable}, 32'd0);
    chk("b2b:setup_cmd_rdy", {31'd0, icb_cmd_rdy}, 32'd0);
    cyc();
    chk("b2b:acc_penable", {31'd0, apb_penable}, 32'd1);
    cyc();
    check_rsp("b2b_first");
    chk("b2b:rsp_cmd_rdy", {31'd0, icb_cmd_rdy}, 32'd0);
    icb_cmd_write = 1'b0; icb_cmd_addr = 32'h3004;
    exp_q.push_back('{err: 1'b0, rdata: 32'h5566_7788});
    cyc();
    chk("b2b:idle_cmd_rdy", {31'd0, icb_cmd_rdy}, 32'd1);
    chk("b2b:idle_rsp_vld", {31'd0, icb_rsp_vld}, 32'd0);
    chk("b2b:idle_psel", {31'd0, apb_psel}, 32'd0);
    cyc();
    icb_cmd_vld = 1'b0;
    chk("b2b:setup2_psel", {31'd0, apb_psel}, 32'd1);
    chk("b2b:setup2_paddr", apb_paddr, 32'h3004);
    chk("b2b:setup2_pwrite", {31'd0, apb_pwrite}, 32'd0);
    cyc();
    chk("b2b:acc2_penable", {31'd0, apb_penable}, 32'd1);
    cyc();
    check_rsp("b2b_second");
    cyc();
    icb_rsp_rdy = 1'b0;
    chk("b2b:end_rsp_vld", {31'd0, icb_rsp_vld}, 32'd0);

    // Reset in the middle of ACCESS.
    apb_pready = 1'b0;
    icb_cmd_vld = 1'b1; icb_cmd_write = 1'b1; icb_cmd_addr = 32'h4000;
    icb_cmd_wdata = 32'h8888_9999; icb_cmd_wstrb = 4'hF;
    cyc();
    icb_cmd_vld = 1'b0;
    cyc();
    chk("rst_mid:acc_penable", {31'd0, apb_penable}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid:psel", {31'd0, apb_psel}, 32'd0);
    chk("rst_mid:penable", {31'd0, apb_penable}, 32'd0);
    chk("rst_mid:paddr", apb_paddr, 32'd0);
    chk("rst_mid:cmd_rdy", {31'd0, icb_cmd_rdy}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    apb_pready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rst_mid:no_rsp", {31'd0, icb_rsp_vld}, 32'd0);
      chk("rst_mid:no_psel", {31'd0, apb_psel}, 32'd0);
    end
    chk("sb:drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
